// File: rtl/vend_pkg.sv
// ----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending transaction sequencer:
//   - coin codes COIN_1 / COIN_2 / COIN_5 as seen on coin and chg_coin
//   - coin_value(): coin code to credit units (0 marks an invalid code)
//   - state_e: sequencer state encoding
//   - PRICE: product price table in credit units, indexed by product id
// ----------------------------------------------------------------------------
package vend_pkg;

   localparam logic [2:0] COIN_1    = 3'b001;
   localparam logic [2:0] COIN_2    = 3'b010;
   localparam logic [2:0] COIN_5    = 3'b101;
   localparam logic [2:0] COIN_NONE = 3'b000;

   localparam int unsigned PRICE_N = 4;
   localparam int unsigned PRICE [PRICE_N] = '{2, 3, 5, 7};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CREDIT = 2'd1,
      ST_VEND   = 2'd2,
      ST_CHANGE = 2'd3
   } state_e;

   // Zero doubles as "invalid code" so callers need no separate valid flag.
   function automatic logic [2:0] coin_value(input logic [2:0] code);
      case (code)
         COIN_1:  return 3'd1;
         COIN_2:  return 3'd2;
         COIN_5:  return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_change_pick.sv
// ----------------------------------------------------------------------------
// vend_change_pick
// Greedy change denomination: the largest coin not exceeding the credit.
// Ports:
//   credit_i  in  CREDIT_W  remaining credit to pay out
//   coin_o    out 3         coin code to offer (COIN_NONE when credit is 0)
// ----------------------------------------------------------------------------
module vend_change_pick
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 5
) (
   input  logic [CREDIT_W-1:0] credit_i,
   output logic [2:0]          coin_o
);

   always_comb begin
      if (credit_i >= CREDIT_W'(5))      coin_o = COIN_5;
      else if (credit_i >= CREDIT_W'(2)) coin_o = COIN_2;
      else if (credit_i != '0)           coin_o = COIN_1;
      else                               coin_o = COIN_NONE;
   end

endmodule

// File: rtl/vend_seq_ctrl.sv
// ----------------------------------------------------------------------------
// vend_seq_ctrl
// Vending transaction sequencer: accumulates coin credit, checks a selection
// against the price table, runs the dispenser req/ack handshake, then pays
// change largest coin first over a valid/ready hopper handshake.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   coin_valid, coin  coin strobe and code from the acceptor
//   sel_valid, sel    selection strobe and product index from the keypad
//   cancel            refund request
//   disp_req/disp_id  dispense request (held until disp_ack) and product
//   disp_ack          dispenser done
//   chg_valid/chg_coin change coin offered, held until chg_ready
//   chg_ready         hopper accepts the offered coin
//   coin_rej          one-cycle pulse: inserted coin returned
//   sel_err           one-cycle pulse: selection refused
//   credit            current credit
//   busy              high while vending or paying change
// ----------------------------------------------------------------------------
module vend_seq_ctrl
   import vend_pkg::*;
#(
   parameter int NPROD      = 4,
   parameter int CREDIT_W   = 5,
   parameter int MAX_CREDIT = 20,
   parameter int TIMEOUT    = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     coin_valid,
   input  logic [2:0]               coin,
   input  logic                     sel_valid,
   input  logic [$clog2(NPROD)-1:0] sel,
   input  logic                     cancel,
   output logic                     disp_req,
   output logic [$clog2(NPROD)-1:0] disp_id,
   input  logic                     disp_ack,
   output logic                     chg_valid,
   output logic [2:0]               chg_coin,
   input  logic                     chg_ready,
   output logic                     coin_rej,
   output logic                     sel_err,
   output logic [CREDIT_W-1:0]      credit,
   output logic                     busy
);

   localparam int SEL_W = $clog2(NPROD);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [SEL_W-1:0]    disp_id_q, disp_id_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic                coin_rej_q, coin_rej_d;
   logic                sel_err_q, sel_err_d;
   logic                disp_req_q, chg_valid_q, busy_q;
   logic [2:0]          chg_coin_q;

   logic [2:0]          coin_val;
   logic [CREDIT_W:0]   coin_sum;   // one extra bit so the ceiling test cannot wrap
   logic                accepted;
   logic [2:0]          pick_coin;

   // The offered coin is chosen from next-state credit so that the first
   // change coin appears in the same cycle the sequencer enters CHANGE.
   vend_change_pick #(.CREDIT_W(CREDIT_W)) u_pick (
      .credit_i (credit_d),
      .coin_o   (pick_coin)
   );

   assign coin_val = coin_value(coin);
   assign coin_sum = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_val);

   always_comb begin
      // NOTE: every value assigned in this block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      state_d    = state_q;
      credit_d   = credit_q;
      disp_id_d  = disp_id_q;
      timer_d    = timer_q;
      coin_rej_d = 1'b0;
      sel_err_d  = 1'b0;
      accepted   = 1'b0;

      case (state_q)
         ST_IDLE, ST_CREDIT: begin
            // Priority cancel > selection > coin; a coin losing to a
            // higher-priority event is handed back.
            if (cancel) begin
               if (credit_q != '0) begin
                  state_d  = ST_CHANGE;
                  accepted = 1'b1;
               end
               if (coin_valid) coin_rej_d = 1'b1;
            end else if (sel_valid) begin
               if ((int'(sel) < NPROD) && (credit_q >= CREDIT_W'(PRICE[sel]))) begin
                  disp_id_d = sel;
                  state_d   = ST_VEND;
                  accepted  = 1'b1;
               end else begin
                  sel_err_d = 1'b1;
               end
               if (coin_valid) coin_rej_d = 1'b1;
            end else if (coin_valid) begin
               if ((coin_val != 3'd0) && (coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT))) begin
                  credit_d = coin_sum[CREDIT_W-1:0];
                  state_d  = ST_CREDIT;
                  accepted = 1'b1;
               end else begin
                  coin_rej_d = 1'b1;
               end
            end else if ((state_q == ST_CREDIT) && (timer_q == TMR_W'(TIMEOUT))) begin
               state_d = ST_CHANGE;
            end

            // The timer only runs while waiting in CREDIT with nothing accepted.
            if (accepted || (state_d != ST_CREDIT)) timer_d = '0;
            else                                    timer_d = timer_q + TMR_W'(1);
         end

         ST_VEND: begin
            if (coin_valid) coin_rej_d = 1'b1;
            if (sel_valid)  sel_err_d  = 1'b1;
            if (disp_ack) begin
               credit_d = credit_q - CREDIT_W'(PRICE[disp_id_q]);
               state_d  = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
            end
         end

         ST_CHANGE: begin
            if (coin_valid) coin_rej_d = 1'b1;
            if (sel_valid)  sel_err_d  = 1'b1;
            if (chg_valid_q && chg_ready) begin
               credit_d = credit_q - CREDIT_W'(coin_value(chg_coin_q));
               if (credit_d == '0) state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         credit_q    <= '0;
         disp_id_q   <= '0;
         timer_q     <= '0;
         coin_rej_q  <= 1'b0;
         sel_err_q   <= 1'b0;
         disp_req_q  <= 1'b0;
         chg_valid_q <= 1'b0;
         chg_coin_q  <= COIN_NONE;
         busy_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values from before this edge, independent of statement order.
         state_q     <= state_d;
         credit_q    <= credit_d;
         disp_id_q   <= disp_id_d;
         timer_q     <= timer_d;
         coin_rej_q  <= coin_rej_d;
         sel_err_q   <= sel_err_d;
         // Handshake outputs are registered decodes of the next state.
         disp_req_q  <= (state_d == ST_VEND);
         chg_valid_q <= (state_d == ST_CHANGE);
         chg_coin_q  <= (state_d == ST_CHANGE) ? pick_coin : COIN_NONE;
         busy_q      <= (state_d == ST_VEND) || (state_d == ST_CHANGE);
      end
   end

   assign disp_req  = disp_req_q;
   assign disp_id   = disp_id_q;
   assign chg_valid = chg_valid_q;
   assign chg_coin  = chg_coin_q;
   assign coin_rej  = coin_rej_q;
   assign sel_err   = sel_err_q;
   assign credit    = credit_q;
   assign busy      = busy_q;

endmodule

// File: doc/vend_seq_ctrl.md
# vend_seq_ctrl

Transaction sequencer for the vending machine datapath. It accumulates coin credit, checks a product selection against a fixed price table, and drives the product-motor dispense handshake. It then pays change coin-by-coin through a hopper handshake, largest denomination first. It sits between the coin acceptor/keypad front end and the dispenser/hopper back end, and replaces the single-cycle `out`/`change` behaviour with proper request/acknowledge sequencing.

## Interface
- `NPROD`, 4: number of products; `sel` indexes `PRICE[0:NPROD-1]`.
- `CREDIT_W`, 5: credit register width (units).
- `MAX_CREDIT`, 20: credit ceiling (units); a coin that would exceed it is rejected.
- `TIMEOUT`, 255: idle cycles in CREDIT before an automatic refund.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `coin_valid`  in  1  single-cycle coin strobe
- `coin`  in  3  coin code: 3'b001=1, 3'b010=2, 3'b101=5 units; any other code is invalid
- `sel_valid`  in  1  single-cycle selection strobe
- `sel`  in  $clog2(NPROD)  product index
- `cancel`  in  1  single-cycle refund request
- `disp_req`  out  1  dispense request, held until ack
- `disp_id`  out  $clog2(NPROD)  product being dispensed, stable while `disp_req`
- `disp_ack`  in  1  dispenser done (single cycle)
- `chg_valid`  out  1  change coin offered
- `chg_coin`  out  3  coin code offered, stable while `chg_valid`
- `chg_ready`  in  1  hopper accepts coin
- `coin_rej`  out  1  one-cycle pulse: last inserted coin returned
- `sel_err`  out  1  one-cycle pulse: selection refused
- `credit`  out  CREDIT_W  current credit
- `busy`  out  1  high in VEND or CHANGE

## Operation
- States: IDLE, CREDIT, VEND, CHANGE.
- Reset values: state IDLE; all outputs 0; credit 0; timer 0.
- IDLE/CREDIT, same-cycle priority cancel > sel_valid > coin_valid:
  - An event is processed only if no higher-priority event is present in the same cycle.
  - A coin dropped by priority pulses `coin_rej`.
- Coin handling:
  - Valid coin with credit+value ≤ MAX_CREDIT: credit += value; state becomes CREDIT.
  - Invalid code or overflow: credit unchanged; `coin_rej`.
- Selection:
  - `sel` < NPROD and credit ≥ PRICE[sel]: latch `disp_id`; go to VEND.
  - Otherwise: `sel_err`; state unchanged.
- Cancel: credit > 0 goes to CHANGE; credit 0 is ignored.
- Timeout: timer clears on any accepted event; when it reaches TIMEOUT in CREDIT, go to CHANGE.
- VEND:
  - `disp_req` is held high.
  - On `disp_ack`: credit -= PRICE[disp_id]; `disp_req` drops; go to CHANGE if the new credit > 0, else IDLE.
- CHANGE:
  - `chg_coin` is the largest denomination ≤ credit (5, 2, then 1).
  - Each `chg_valid && chg_ready` subtracts that value; the next coin is offered the following cycle.
  - Credit 0 goes to IDLE.
- Any coin in VEND or CHANGE gives `coin_rej`. `sel_valid`/`cancel` in VEND or CHANGE give `sel_err` / are ignored.
- Async reset mid-transaction abandons the credit. `disp_req`/`chg_valid` drop immediately, with no refund.

## Timing
- All outputs are registered. An event sampled at edge N is reflected in `credit`/state/pulses after edge N.
- Coin to credit update: 1 cycle. Selection to `disp_req`: 1 cycle.
- `disp_ack` to `disp_req` low and credit decremented: 1 cycle. First `chg_valid` is high the same cycle.
- Change throughput: 1 coin/cycle when `chg_ready` is held high.
- `chg_valid`/`chg_coin` must not change or drop until `chg_ready`.
- `disp_ack` outside VEND and `chg_ready` outside CHANGE are ignored.
- Arithmetic is unsigned CREDIT_W; MAX_CREDIT < 2^CREDIT_W.

## Structure
- Package `vend_pkg`: coin code localparams (COIN_1/2/5), `coin_value()` decode function, state enum, `PRICE` constant array {2,3,5,7}.
- One sub-module, `vend_change_pick`: combinational greedy denomination choice from the credit value.

## Test plan
- Insert 2, 2, 1, select 2 (price 5), ack after 3 cycles → `disp_req` 3 cycles with `disp_id`=2; credit 0; no `chg_valid`; back to IDLE.
- Insert 5, 5, select 3 (price 7), ack → change coins 2 then 1 with `chg_ready`=1; credit 3→1→0.
- Insert 5 ×4 (credit 20), insert 1 → `coin_rej` pulse, credit stays 20; insert code 3'b011 → `coin_rej`.
- Credit 2, select 1 (price 3) → `sel_err`, credit 2. Same-cycle coin+sel → sel evaluated, coin rejected.
- Credit 8, cancel, `chg_ready` stalled 2 cycles per coin → 5, 2, 1 each held stable until accepted; idle → TIMEOUT refund also exercised.
- Assert `rst_n` low during CHANGE → all outputs 0 asynchronously; after release, state IDLE and credit 0.
